// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response codes and packed-channel field offsets
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AR/AW layout: {ID, ADDR, LEN[7:0], SIZE[2:0], BURST[1:0]}
  localparam int AX_LEN_W     = 8;
  localparam int AX_BURST_LSB = 0;
  localparam int AX_SIZE_LSB  = 2;
  localparam int AX_LEN_LSB   = 5;
  localparam int AX_ADDR_LSB  = 13;

  // W layout: {DATA, STRB, LAST}
  localparam int W_LAST_BIT = 0;
  localparam int W_STRB_LSB = 1;

  function automatic int ax_id_lsb(input int addr_w);
    return AX_ADDR_LSB + addr_w;
  endfunction

  function automatic int w_data_lsb(input int data_w);
    return W_STRB_LSB + data_w / 8;
  endfunction

  // R layout: {DATA, RESP[1:0], LAST, ID}
  function automatic int r_last_bit(input int id_w);
    return id_w;
  endfunction

  function automatic int r_resp_lsb(input int id_w);
    return id_w + 1;
  endfunction

  function automatic int r_data_lsb(input int id_w);
    return id_w + 3;
  endfunction

  // B layout: {RESP[1:0], ID}
  function automatic int b_resp_lsb(input int id_w);
    return id_w;
  endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// rtl/axi_sync_fifo.sv - parametrised synchronous FIFO with full/empty flags
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset; only slots behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_misrouting_slave.sv
// rtl/axi_misrouting_slave.sv - default slave answering unmapped AXI bursts with an error response
module axi_misrouting_slave
  import axi_pkg::*;
#(
  parameter int          AXI_ID_WIDTH     = 1,
  parameter int          AXI_DATA_WIDTH   = 32,
  parameter int          AXI_ADDR_WIDTH   = 8,
  parameter int          AXI_ARCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  parameter int          AXI_AWCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  parameter int          AXI_WDCHAN_WIDTH = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1,
  parameter int          AXI_RDCHAN_WIDTH = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3,
  parameter int          AXI_BCHAN_WIDTH  = AXI_ID_WIDTH + 2,
  parameter int          RD_DEPTH         = 4,
  parameter logic [1:0]  RESP_CODE        = RESP_DECERR,
  parameter int          ERR_CNT_WIDTH    = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [AXI_ARCHAN_WIDTH-1:0] S_AXI_ARCH_i,
  input  logic                        S_AXI_ARCH_VALID_i,
  output logic                        S_AXI_ARCH_READY_o,
  output logic [AXI_RDCHAN_WIDTH-1:0] S_AXI_RCH_o,
  output logic                        S_AXI_RCH_VALID_o,
  input  logic                        S_AXI_RCH_READY_i,
  input  logic [AXI_AWCHAN_WIDTH-1:0] S_AXI_AWCH_i,
  input  logic                        S_AXI_AWCH_VALID_i,
  output logic                        S_AXI_AWCH_READY_o,
  input  logic [AXI_WDCHAN_WIDTH-1:0] S_AXI_WCH_i,
  input  logic                        S_AXI_WCH_VALID_i,
  output logic                        S_AXI_WCH_READY_o,
  output logic [AXI_BCHAN_WIDTH-1:0]  S_AXI_BCH_o,
  output logic                        S_AXI_BCH_VALID_o,
  input  logic                        S_AXI_BCH_READY_i,
  output logic [ERR_CNT_WIDTH-1:0]    RD_ERR_CNT_o,
  output logic [ERR_CNT_WIDTH-1:0]    WR_ERR_CNT_o
);

  localparam int AX_ID_LSB = ax_id_lsb(AXI_ADDR_WIDTH);
  localparam int Q_WIDTH   = AXI_ID_WIDTH + AX_LEN_W;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DRAIN,
    W_RESP
  } w_state_t;

  // ---------------- read path ----------------
  logic [AXI_ID_WIDTH-1:0]  ar_id;
  logic [AX_LEN_W-1:0]      ar_len;
  logic [Q_WIDTH-1:0]       q_head;
  logic [AXI_ID_WIDTH-1:0]  head_id;
  logic [AX_LEN_W-1:0]      head_len;
  logic                     q_full;
  logic                     q_empty;
  logic                     ar_hs;
  logic                     r_hs;
  logic                     r_last;
  logic [AX_LEN_W-1:0]      beat_cnt;
  logic [ERR_CNT_WIDTH-1:0] rd_err_cnt;

  assign ar_id  = S_AXI_ARCH_i[AX_ID_LSB +: AXI_ID_WIDTH];
  assign ar_len = S_AXI_ARCH_i[AX_LEN_LSB +: AX_LEN_W];

  assign S_AXI_ARCH_READY_o = !q_full;
  assign ar_hs              = S_AXI_ARCH_VALID_i && !q_full;

  axi_sync_fifo #(
    .WIDTH (Q_WIDTH),
    .DEPTH (RD_DEPTH)
  ) u_ar_queue (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (ar_hs),
    .push_data ({ar_id, ar_len}),
    .pop       (r_hs && r_last),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign head_id  = q_head[AX_LEN_W +: AXI_ID_WIDTH];
  assign head_len = q_head[AX_LEN_W-1:0];

  assign S_AXI_RCH_VALID_o = !q_empty;
  assign r_hs              = !q_empty && S_AXI_RCH_READY_i;
  assign r_last            = (beat_cnt == head_len);
  assign S_AXI_RCH_o       = {{AXI_DATA_WIDTH{1'b0}}, RESP_CODE, r_last, head_id};
  assign RD_ERR_CNT_o      = rd_err_cnt;

  // Beat position within the head burst; completing a burst bumps the read error count.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      beat_cnt   <= '0;
      rd_err_cnt <= '0;
    end else if (r_hs) begin
      if (r_last) begin
        beat_cnt <= '0;
        if (rd_err_cnt != '1) rd_err_cnt <= rd_err_cnt + ERR_CNT_WIDTH'(1);
      end else begin
        beat_cnt <= beat_cnt + AX_LEN_W'(1);
      end
    end
  end

  // ---------------- write path ----------------
  w_state_t                 w_state;
  w_state_t                 w_state_nxt;
  logic [AXI_ID_WIDTH-1:0]  wr_id;
  logic [ERR_CNT_WIDTH-1:0] wr_err_cnt;
  logic                     w_last;

  assign w_last       = S_AXI_WCH_i[W_LAST_BIT];
  assign S_AXI_BCH_o  = {RESP_CODE, wr_id};
  assign WR_ERR_CNT_o = wr_err_cnt;

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // Next state and channel handshakes; WLAST alone ends the burst, AWLEN is not consulted.
  always_comb begin
    w_state_nxt        = w_state;
    S_AXI_AWCH_READY_o = 1'b0;
    S_AXI_WCH_READY_o  = 1'b0;
    S_AXI_BCH_VALID_o  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWCH_READY_o = 1'b1;
        if (S_AXI_AWCH_VALID_i) w_state_nxt = W_DRAIN;
      end
      W_DRAIN: begin
        S_AXI_WCH_READY_o = 1'b1;
        if (S_AXI_WCH_VALID_i && w_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BCH_VALID_o = 1'b1;
        if (S_AXI_BCH_READY_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Capture the AW ID for the B response and count completed writes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_id      <= '0;
      wr_err_cnt <= '0;
    end else begin
      if (w_state == W_IDLE && S_AXI_AWCH_VALID_i)
        wr_id <= S_AXI_AWCH_i[AX_ID_LSB +: AXI_ID_WIDTH];
      if (w_state == W_RESP && S_AXI_BCH_READY_i && wr_err_cnt != '1)
        wr_err_cnt <= wr_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  // Address, size, burst, AWLEN, write data and strobes are deliberately ignored.
  logic unused_payload;
  assign unused_payload = ^{S_AXI_ARCH_i[AX_LEN_LSB-1:0],
                            S_AXI_ARCH_i[AX_ID_LSB-1:AX_LEN_LSB+AX_LEN_W],
                            S_AXI_AWCH_i[AX_ID_LSB-1:0],
                            S_AXI_WCH_i[AXI_WDCHAN_WIDTH-1:1]};

endmodule

// File: tb/tb_axi_misrouting_slave.sv
// tb/tb_axi_misrouting_slave.sv - randomized and directed bench with a queue-based reference model
module tb_axi_misrouting_slave;

  localparam int ARW = 22;
  localparam int WW  = 37;
  localparam int RW  = 36;
  localparam int BW  = 3;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [ARW-1:0] ar    = '0;
  logic [ARW-1:0] awp   = '0;
  logic [WW-1:0]  wp    = '0;
  logic           arv   = 1'b0;
  logic           awv   = 1'b0;
  logic           wv    = 1'b0;
  logic           rrdy  = 1'b0;
  logic           brdy  = 1'b0;

  logic          arrdy [2];
  logic          rv    [2];
  logic          awrdy [2];
  logic          wrdy  [2];
  logic          bv    [2];
  logic [RW-1:0] rch   [2];
  logic [BW-1:0] bch   [2];
  logic [15:0]   rcnt0, wcnt0;
  logic [1:0]    rcnt1, wcnt1;

  int errors = 0;
  int checks = 0;

  // Reference model state: queued bursts, beat index in head burst, write phase.
  int q_id [$];
  int q_len [$];
  int bi      = 0;
  int wph     = 0;   // 0 waiting for AW, 1 draining W, 2 responding
  int wid     = 0;
  int rd_done = 0;
  int wr_done = 0;

  always #5 clk = ~clk;

  axi_misrouting_slave dut0 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_ARCH_i(ar), .S_AXI_ARCH_VALID_i(arv), .S_AXI_ARCH_READY_o(arrdy[0]),
    .S_AXI_RCH_o(rch[0]), .S_AXI_RCH_VALID_o(rv[0]), .S_AXI_RCH_READY_i(rrdy),
    .S_AXI_AWCH_i(awp), .S_AXI_AWCH_VALID_i(awv), .S_AXI_AWCH_READY_o(awrdy[0]),
    .S_AXI_WCH_i(wp), .S_AXI_WCH_VALID_i(wv), .S_AXI_WCH_READY_o(wrdy[0]),
    .S_AXI_BCH_o(bch[0]), .S_AXI_BCH_VALID_o(bv[0]), .S_AXI_BCH_READY_i(brdy),
    .RD_ERR_CNT_o(rcnt0), .WR_ERR_CNT_o(wcnt0)
  );

  axi_misrouting_slave #(.RESP_CODE(2'b10), .ERR_CNT_WIDTH(2)) dut1 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_ARCH_i(ar), .S_AXI_ARCH_VALID_i(arv), .S_AXI_ARCH_READY_o(arrdy[1]),
    .S_AXI_RCH_o(rch[1]), .S_AXI_RCH_VALID_o(rv[1]), .S_AXI_RCH_READY_i(rrdy),
    .S_AXI_AWCH_i(awp), .S_AXI_AWCH_VALID_i(awv), .S_AXI_AWCH_READY_o(awrdy[1]),
    .S_AXI_WCH_i(wp), .S_AXI_WCH_VALID_i(wv), .S_AXI_WCH_READY_o(wrdy[1]),
    .S_AXI_BCH_o(bch[1]), .S_AXI_BCH_VALID_o(bv[1]), .S_AXI_BCH_READY_i(brdy),
    .RD_ERR_CNT_o(rcnt1), .WR_ERR_CNT_o(wcnt1)
  );

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s actual=%0h required=%0h at %0t", d, nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  function automatic logic [ARW-1:0] mk_ax(input logic id, input logic [7:0] len);
    logic [7:0] addr;
    addr = 8'($urandom);
    return {id, addr, len, 3'b010, 2'b01};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare both DUTs against the model every cycle, then advance the model to the next edge.
  always @(negedge clk) begin : model
    logic [1:0] resp;
    logic [63:0] rc, wc;
    int cw;
    bit r_hs, ar_hs;
    if (!rst_n) begin
      q_id.delete();
      q_len.delete();
      bi = 0; wph = 0; rd_done = 0; wr_done = 0;
    end
    for (int d = 0; d < 2; d++) begin
      resp = (d == 0) ? 2'b11 : 2'b10;
      cw   = (d == 0) ? 16 : 2;
      rc   = (d == 0) ? 64'(rcnt0) : 64'(rcnt1);
      wc   = (d == 0) ? 64'(wcnt0) : 64'(wcnt1);
      chk(d, "arready", arrdy[d], q_id.size() < 4);
      chk(d, "rvalid", rv[d], q_id.size() > 0);
      if (q_id.size() > 0) begin
        chk(d, "rid", rch[d][0], q_id[0]);
        chk(d, "rlast", rch[d][1], bi == q_len[0]);
        chk(d, "rresp", rch[d][3:2], resp);
        chk(d, "rdata", rch[d][35:4], 0);
      end
      chk(d, "awready", awrdy[d], wph == 0);
      chk(d, "wready", wrdy[d], wph == 1);
      chk(d, "bvalid", bv[d], wph == 2);
      if (wph == 2) chk(d, "bpayload", bch[d], {resp, wid[0]});
      chk(d, "rd_err_cnt", rc, sat(rd_done, cw));
      chk(d, "wr_err_cnt", wc, sat(wr_done, cw));
    end
    if (rst_n) begin
      r_hs  = (q_id.size() > 0) && rrdy;
      ar_hs = arv && (q_id.size() < 4);
      if (r_hs) begin
        if (bi == q_len[0]) begin
          void'(q_id.pop_front());
          void'(q_len.pop_front());
          bi = 0;
          rd_done++;
        end else begin
          bi++;
        end
      end
      if (ar_hs) begin
        q_id.push_back(int'(ar[21]));
        q_len.push_back(int'(ar[12:5]));
      end
      case (wph)
        0: if (awv) begin wid = int'(awp[21]); wph = 1; end
        1: if (wv && wp[0]) wph = 2;
        default: if (brdy) begin wph = 0; wr_done++; end
      endcase
    end
  end

  initial begin : stim
    int beats, lastpos, acc, hs;
    logic [4:0] idseq;

    // Reset
    repeat (3) step();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "reset_rvalid", rv[d], 0);
      chk(d, "reset_arready", arrdy[d], 1);
      chk(d, "reset_awready", awrdy[d], 1);
      chk(d, "reset_bvalid", bv[d], 0);
    end

    // Single read ID=1 LEN=3
    ar = mk_ax(1'b1, 8'd3); arv = 1'b1; rrdy = 1'b1;
    step();
    arv = 1'b0;
    chk(0, "single_rid", rch[0][0], 1);
    beats = 0; lastpos = 0;
    for (int k = 0; k < 20; k++) begin
      if (rv[0]) begin
        beats++;
        if (rch[0][1]) lastpos = beats;
      end
      step();
    end
    chk(0, "single_beats", beats, 4);
    chk(0, "single_lastpos", lastpos, 4);
    chk(0, "single_cnt", rcnt0, 1);

    // Outstanding reads, IDs 0..4 (1-bit ID keeps the LSB), LEN=0
    rrdy = 1'b0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      ar = mk_ax(1'(i), 8'd0); arv = 1'b1;
      acc += int'(arrdy[0]);
      step();
    end
    arv = 1'b0;
    chk(0, "outst_accepted", acc, 4);
    chk(0, "outst_full_arready", arrdy[0], 0);
    rrdy = 1'b1;
    idseq = {4'b0, rch[0][0]};
    step();
    chk(0, "outst_arready_after_pop", arrdy[0], 1);
    ar = mk_ax(1'b0, 8'd0); arv = 1'b1;
    beats = 1;
    for (int k = 0; k < 10; k++) begin
      if (rv[0]) begin
        idseq = {idseq[3:0], rch[0][0]};
        beats++;
      end
      step();
      arv = 1'b0;
    end
    chk(0, "outst_beats", beats, 5);
    chk(0, "outst_id_order", idseq, 5'b01010);
    chk(1, "saturated_rd_cnt", rcnt1, 3);
    chk(0, "rd_cnt_6", rcnt0, 6);

    // Read backpressure LEN=2 with RREADY toggling
    ar = mk_ax(1'b1, 8'd2); arv = 1'b1; rrdy = 1'b0;
    step();
    arv = 1'b0; hs = 0;
    for (int k = 0; k < 12; k++) begin
      rrdy = 1'(k % 2);
      if (rv[0] && rrdy) hs++;
      step();
    end
    chk(0, "bp_handshakes", hs, 3);

    // Write with W presented before AW
    rrdy = 1'b0;
    wp = {32'hDEAD_BEEF, 4'hF, 1'b0}; wv = 1'b1;
    step(); step();
    chk(0, "w_held_off", wrdy[0], 0);
    awp = mk_ax(1'b1, 8'd5); awv = 1'b1;
    step();
    awv = 1'b0;
    chk(0, "w_drain_wready", wrdy[0], 1);
    chk(0, "w_drain_awready", awrdy[0], 0);
    for (int k = 0; k < 3; k++) begin
      wp[0] = (k == 2);
      step();
    end
    wv = 1'b0;
    chk(0, "b_valid", bv[0], 1);
    chk(0, "b_payload", bch[0], 3'b111);
    chk(1, "b_payload_slverr", bch[1], 3'b101);
    step(); step();
    chk(0, "b_held", bv[0], 1);
    brdy = 1'b1;
    step();
    brdy = 1'b0;
    chk(0, "wr_cnt_1", wcnt0, 1);

    // Concurrent read LEN=7 and 2-beat write
    rrdy = 1'b1; brdy = 1'b1;
    ar = mk_ax(1'b0, 8'd7); arv = 1'b1;
    awp = mk_ax(1'b0, 8'd1); awv = 1'b1;
    step();
    arv = 1'b0; awv = 1'b0; wv = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wp = {32'(k), 4'h3, 1'(k == 1)};
      step();
    end
    wv = 1'b0;
    repeat (12) step();
    chk(0, "conc_rd_cnt", rcnt0, 8);
    chk(0, "conc_wr_cnt", wcnt0, 2);
    chk(1, "conc_wr_cnt_slverr", wcnt1, 2);

    // Reset during R beat 2 of LEN=7
    ar = mk_ax(1'b1, 8'd7); arv = 1'b1;
    step();
    arv = 1'b0;
    step(); step();
    chk(0, "pre_reset_rvalid", rv[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "async_rvalid", rv[0], 0);
    chk(1, "async_rvalid", rv[1], 0);
    step(); step();
    rst_n = 1'b1;
    chk(0, "post_reset_arready", arrdy[0], 1);
    chk(0, "post_reset_awready", awrdy[0], 1);
    chk(0, "post_reset_rd_cnt", rcnt0, 0);
    chk(0, "post_reset_wr_cnt", wcnt0, 0);

    // Reset in W_DRAIN
    awp = mk_ax(1'b1, 8'd3); awv = 1'b1;
    step();
    awv = 1'b0;
    chk(0, "drain_before_reset", wrdy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "async_wready", wrdy[0], 0);
    chk(0, "async_awready", awrdy[0], 1);
    step(); step();
    rst_n = 1'b1;

    // Fresh LEN=0 read
    ar = mk_ax(1'b0, 8'd0); arv = 1'b1; rrdy = 1'b1;
    step();
    arv = 1'b0; beats = 0; lastpos = 0;
    for (int k = 0; k < 5; k++) begin
      if (rv[0]) begin
        beats++;
        if (rch[0][1]) lastpos = beats;
      end
      step();
    end
    chk(0, "fresh_beats", beats, 1);
    chk(0, "fresh_last", lastpos, 1);
    chk(0, "fresh_cnt", rcnt0, 1);

    // Randomized traffic on both channels
    for (int k = 0; k < 3000; k++) begin
      arv  = 1'($urandom % 2);
      ar   = mk_ax(1'($urandom), 8'($urandom_range(0, 7)));
      rrdy = 1'($urandom % 4 != 0);
      awv  = 1'($urandom % 2);
      awp  = mk_ax(1'($urandom), 8'($urandom));
      wv   = 1'($urandom % 2);
      wp   = {32'($urandom), 4'($urandom), 1'($urandom % 3 == 0)};
      brdy = 1'($urandom % 2);
      step();
    end
    arv = 1'b0; awv = 1'b0; wv = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
